// File: rtl/axi_rd_arb.sv
// Two-master AXI read-address/read-data arbiter, one burst in flight at a time.
// Define AXI_RD_ARB_FIXED_PRI_EN for fixed priority (master 0 wins); default is round-robin.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi_rd_arb (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   m_arvalid,
    output logic [1:0]                   m_arready,
    input  logic [2*`AXI_ADDR_WIDTH-1:0] m_araddr,
    input  logic [2*`AXI_LEN_WIDTH-1:0]  m_arlen,
    output logic [1:0]                   m_rvalid,
    input  logic [1:0]                   m_rready,
    output logic [`AXI_DATA_WIDTH-1:0]   m_rdata,
    output logic                         m_rlast,
    output logic                         s_arvalid,
    input  logic                         s_arready,
    output logic [`AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic [`AXI_LEN_WIDTH-1:0]    s_arlen,
    input  logic                         s_rvalid,
    output logic                         s_rready,
    input  logic [`AXI_DATA_WIDTH-1:0]   s_rdata,
    input  logic                         s_rlast,
    output logic                         arb_busy,
    output logic                         arb_owner
);

    localparam int AW = `AXI_ADDR_WIDTH;
    localparam int LW = `AXI_LEN_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [LW-1:0]   arlen_q, arlen_d;
    logic            winner;
    logic            req_any;
    logic            burst_done;

    assign req_any    = |m_arvalid;
    assign burst_done = s_rvalid & s_rready & s_rlast;

`ifdef AXI_RD_ARB_FIXED_PRI_EN
    assign winner = ~m_arvalid[0];
`else
    logic last_grant_q, last_grant_d;

    // Contended requests go to whoever did not finish the previous burst
    always_comb begin
        winner = 1'b0;
        unique case (m_arvalid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == DATA && burst_done) begin
            last_grant_d = owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            araddr_q <= '0;
            arlen_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d  = ADDR;
                    owner_d  = winner;
                    araddr_d = winner ? m_araddr[2*AW-1:AW]
                                      : m_araddr[AW-1:0];
                    arlen_d  = winner ? m_arlen[2*LW-1:LW]
                                      : m_arlen[LW-1:0];
                end
            end
            ADDR: begin
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (burst_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while rst is asserted
    always_comb begin
        m_arready = 2'b00;
        m_rvalid  = 2'b00;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        arb_busy  = 1'b0;
        arb_owner = 1'b0;
        if (!rst) begin
            arb_busy  = (state_q != IDLE);
            arb_owner = owner_q;
            unique case (state_q)
                IDLE: m_arready[winner] = req_any;
                ADDR: s_arvalid = 1'b1;
                DATA: begin
                    m_rvalid[owner_q] = s_rvalid;
                    s_rready          = m_rready[owner_q];
                end
                default: ;
            endcase
        end
    end

    assign m_rdata  = s_rdata;
    assign m_rlast  = s_rlast;
    assign s_araddr = araddr_q;
    assign s_arlen  = arlen_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Scoreboard bench for axi_rd_arb: directed requests, a small slave agent,
// and a monitor that checks grants, address phases and delivered beats.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module tb_axi_rd_arb;

    localparam int AW = `AXI_ADDR_WIDTH;
    localparam int LW = `AXI_LEN_WIDTH;
    localparam int DW = `AXI_DATA_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      m_arvalid;
    logic [1:0]      m_arready;
    logic [2*AW-1:0] m_araddr;
    logic [2*LW-1:0] m_arlen;
    logic [1:0]      m_rvalid;
    logic [1:0]      m_rready;
    logic [DW-1:0]   m_rdata;
    logic            m_rlast;
    logic            s_arvalid;
    logic            s_arready;
    logic [AW-1:0]   s_araddr;
    logic [LW-1:0]   s_arlen;
    logic            s_rvalid;
    logic            s_rready;
    logic [DW-1:0]   s_rdata;
    logic            s_rlast;
    logic            arb_busy;
    logic            arb_owner;

    axi_rd_arb dut (
        .clk       (clk),
        .rst       (rst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rlast   (m_rlast),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .arb_busy  (arb_busy),
        .arb_owner (arb_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          m;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    int                  exp_grant[$];
    logic [AW+LW-1:0]    exp_ar[$];
    beat_t               exp_beat[$];

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;

    // slave / master agent state, driven only by the stimulus process
    int            sl_phase;
    logic [AW-1:0] sl_addr;
    logic [LW-1:0] sl_len;
    int            sl_beat;
    int            stall_cnt;
    int            ar_stall;
    logic          rr_en;
    int            rr_idx;
    logic [3:0]    rr_pat;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected response for one request: its grant, its address phase,
    // and beats carrying addr+k with last on beat len
    task automatic push_req(int m, logic [AW-1:0] addr, int len);
        beat_t b;
        exp_grant.push_back(m);
        exp_ar.push_back({addr, LW'(len)});
        for (int k = 0; k <= len; k++) begin
            b.m = (m != 0);
            b.d = DW'(addr) + DW'(k);
            b.l = (k == len);
            exp_beat.push_back(b);
        end
    endtask

    task automatic req(int m, logic [AW-1:0] addr, int len);
        if (m == 0) begin
            m_araddr[AW-1:0]   = addr;
            m_arlen[LW-1:0]    = LW'(len);
            m_arvalid[0]       = 1'b1;
        end else begin
            m_araddr[2*AW-1:AW] = addr;
            m_arlen[2*LW-1:LW]  = LW'(len);
            m_arvalid[1]        = 1'b1;
        end
    endtask

    task automatic present();
        s_rvalid = 1'b1;
        s_rdata  = DW'(sl_addr) + DW'(sl_beat);
        s_rlast  = (sl_beat == int'(sl_len));
    endtask

    // One clock: sample handshakes at negedge, update agents after posedge
    task automatic tick();
        logic       arhs;
        logic       rhs;
        logic [1:0] mhs;
        @(negedge clk);
        arhs = s_arvalid & s_arready;
        rhs  = s_rvalid & s_rready;
        mhs  = m_arvalid & m_arready;
        if (arhs) begin
            sl_addr = s_araddr;
            sl_len  = s_arlen;
        end
        @(posedge clk);
        #1;
        m_arvalid = m_arvalid & ~mhs;
        if (rr_en) begin
            m_rready = {2{rr_pat[rr_idx]}};
            rr_idx   = (rr_idx + 1) % 4;
        end
        if (rst) begin
            sl_phase  = 0;
            s_arready = 1'b0;
            s_rvalid  = 1'b0;
            s_rlast   = 1'b0;
            stall_cnt = 0;
        end else if (sl_phase == 0) begin
            s_rvalid = 1'b0;
            s_rlast  = 1'b0;
            if (arhs) begin
                sl_phase  = 1;
                sl_beat   = 0;
                s_arready = 1'b0;
                stall_cnt = 0;
                present();
            end else if (s_arvalid) begin
                if (stall_cnt < ar_stall) begin
                    stall_cnt++;
                    s_arready = 1'b0;
                end else begin
                    s_arready = 1'b1;
                end
            end else begin
                s_arready = 1'b0;
            end
        end else if (rhs) begin
            if (s_rlast) begin
                sl_phase = 0;
                s_rvalid = 1'b0;
                s_rlast  = 1'b0;
            end else begin
                sl_beat++;
                present();
            end
        end
    endtask

    task automatic wait_idle(int max, string name);
        int n = 0;
        while ((arb_busy || m_arvalid != 2'b00 || exp_beat.size() != 0 ||
                exp_grant.size() != 0 || exp_ar.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, 64'({arb_busy, (n >= max)}), 64'(0));
    endtask

    task automatic chk_quiet(string name);
        chk(name, 64'({s_arvalid, s_rready, m_arready, m_rvalid,
                       arb_busy, arb_owner}), 64'(0));
    endtask

    // Monitor: consumes scoreboard entries whenever the DUT shows a handshake
    always @(negedge clk) begin
        beat_t            b;
        logic [AW+LW-1:0] a;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (m_arvalid[i] && m_arready[i]) begin
                    if (exp_grant.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant: unexpected grant to master %0d", i);
                    end else begin
                        chk("grant", 64'(i), 64'(exp_grant.pop_front()));
                    end
                end
            end
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar: unexpected address %0h", s_araddr);
                end else begin
                    a = exp_ar.pop_front();
                    chk("ar_addr_len", 64'({s_araddr, s_arlen}), 64'(a));
                end
            end
            chk("rvalid_onehot", 64'(m_rvalid == 2'b11), 64'(0));
            if (|m_rvalid) begin
                chk("s_rready_mirror", 64'(s_rready), 64'(m_rready[arb_owner]));
            end
            for (int i = 0; i < 2; i++) begin
                if (m_rvalid[i] && m_rready[i]) begin
                    beats_seen++;
                    if (exp_beat.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat: unexpected beat %0h to master %0d",
                                 m_rdata, i);
                    end else begin
                        b = exp_beat.pop_front();
                        chk("beat_master", 64'(i), 64'(b.m));
                        chk("beat_data", 64'(m_rdata), 64'(b.d));
                        chk("beat_last", 64'(m_rlast), 64'(b.l));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        rst       = 1'b1;
        m_arvalid = 2'b00;
        m_araddr  = '0;
        m_arlen   = '0;
        m_rready  = 2'b11;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rlast   = 1'b0;
        sl_phase  = 0;
        sl_addr   = '0;
        sl_len    = '0;
        sl_beat   = 0;
        stall_cnt = 0;
        ar_stall  = 0;
        rr_en     = 1'b0;
        rr_idx    = 0;
        rr_pat    = 4'b1001;

        // reset state, including gating of requests presented during reset
        repeat (2) tick();
        m_arvalid = 2'b11;
        #1;
        chk_quiet("rst_outputs");
        chk("rst_araddr", 64'(s_araddr), 64'(0));
        chk("rst_arlen", 64'(s_arlen), 64'(0));
        m_arvalid = 2'b00;
        rst = 1'b0;
        tick();
        chk_quiet("post_rst_outputs");

        // single request, len=3
        req(0, 'h100, 3);
        push_req(0, 'h100, 3);
        #1;
        chk("t1_arready_comb", 64'(m_arready), 64'(2'b01));
        tick();
        chk("t1_s_arvalid", 64'(s_arvalid), 64'(1));
        chk("t1_s_araddr", 64'(s_araddr), 64'('h100));
        chk("t1_s_arlen", 64'(s_arlen), 64'(3));
        chk("t1_busy", 64'(arb_busy), 64'(1));
        wait_idle(50, "t1");

        // simultaneous requests after reset, master 0 re-requests
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req(0, 'h200, 1);
        req(1, 'h300, 2);
        push_req(0, 'h200, 1);
        tick();
        chk("t2_first_owner", 64'(arb_owner), 64'(0));
        req(0, 'h280, 0);
`ifdef AXI_RD_ARB_FIXED_PRI_EN
        push_req(0, 'h280, 0);
        push_req(1, 'h300, 2);
`else
        push_req(1, 'h300, 2);
        push_req(0, 'h280, 0);
`endif
        wait_idle(100, "t2");

        // master-side backpressure 1,0,0,1 on a len=3 burst
        b0 = beats_seen;
        rr_en  = 1'b1;
        rr_idx = 0;
        req(1, 'h400, 3);
        push_req(1, 'h400, 3);
        wait_idle(100, "t3");
        rr_en    = 1'b0;
        m_rready = 2'b11;
        chk("t3_beat_count", 64'(beats_seen - b0), 64'(4));

        // slave address stall while the other master waits
        ar_stall = 5;
        req(0, 'h500, 1);
        push_req(0, 'h500, 1);
        tick();
        req(1, 'h600, 0);
        push_req(1, 'h600, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_s_arvalid", 64'(s_arvalid), 64'(1));
            chk("t4_s_ar_stable", 64'({s_araddr, s_arlen}),
                64'({AW'('h500), LW'(1)}));
            chk("t4_m_arready", 64'(m_arready), 64'(0));
        end
        ar_stall = 0;
        wait_idle(100, "t4");

        // reset during beat 2 of 4
        b0 = beats_seen;
        n  = 0;
        req(0, 'h700, 3);
        push_req(0, 'h700, 3);
        while (beats_seen - b0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reach_beat2", 64'(n >= 50), 64'(0));
        rst = 1'b1;
        tick();
        chk_quiet("t5_in_reset");
        chk("t5_pending_beats", 64'(exp_beat.size()), 64'(2));
        exp_beat.delete();
        rst = 1'b0;
        tick();
        chk_quiet("t5_after_reset");
        req(0, 'h800, 0);
        req(1, 'h900, 0);
        push_req(0, 'h800, 0);
        push_req(1, 'h900, 0);
        #1;
        chk("t5_fresh_grant", 64'(m_arready), 64'(2'b01));
        wait_idle(100, "t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
